matrix_bus_top: RTL and testbench

- Single-master bus subsystem with an internal compute master (M1).
- Contains:
  - A and B 2x2 matrix register files.
  - Two operand FIFOs.
  - A FIFO-fed 2x2 matrix multiplier that writes results to C.
  - A matrix adder that writes results to D.
  - A two-master arbiter: external M0 versus the internal engine M1.
- Sits between a host bus master (M0) and downstream logic; raises an interrupt when the add operation completes.

---
 rtl/matrix_bus_top.sv | 239 +++++++++++++++++++++++
 tb/tb_matrix_bus_top.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_bus_top.sv
// rtl/matrix_bus_top.sv - 2x2 matrix multiply/add engine behind a two-master bus arbiter.
// Optional MATRIX_SAT_EN: saturate multiply-accumulate and add at all-ones instead of wrapping.

module matrix_bus_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          full, empty, do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty;
    // Popping an empty FIFO reads as zero so the engine needs no stall path.
    assign rdata_o = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop)
                rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module matrix_bus_top #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              M0_req,
    input  logic              M0_wr,
    input  logic [7:0]        M0_address,
    input  logic [DATA_W-1:0] M0_dout,
    output logic              M0_grant,
    output logic              M1_grant,
    output logic [DATA_W-1:0] M_din,
    output logic              m_interrupt,
    output logic              multi_opdone
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] a_q [4];
    logic [DATA_W-1:0] b_q [4];
    logic [DATA_W-1:0] c_q [4];
    logic [DATA_W-1:0] d_q [4];
    logic [DATA_W-1:0] m_din_q, rdata, fa, fb, mul_sum, add_sum;
    logic              m0_grant_q, int_en_q, mul_done_q, add_done_q;
    logic              busy, acc_en, wr_en, rd_en, start_mul, start_add;
    logic              pop, c_we, d_we, mul_fin, add_fin;
    logic [1:0]        idx;

    function automatic logic [DATA_W-1:0] f_add(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
`ifdef MATRIX_SAT_EN
        logic [DATA_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[DATA_W] ? '1 : s[DATA_W-1:0];
`else
        return x + y;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] f_mul(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
`ifdef MATRIX_SAT_EN
        logic [2*DATA_W-1:0] p;
        p = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
        return (p[2*DATA_W-1:DATA_W] != '0) ? '1 : p[DATA_W-1:0];
`else
        return x * y;
`endif
    endfunction

    assign busy         = (state_q != S_IDLE);
    assign M1_grant     = busy;
    assign M0_grant     = m0_grant_q & ~busy;
    assign M_din        = m_din_q;
    assign m_interrupt  = add_done_q & int_en_q;
    assign multi_opdone = mul_done_q;

    assign acc_en    = M0_grant & M0_req;
    assign wr_en     = acc_en & M0_wr;
    assign rd_en     = acc_en & ~M0_wr;
    assign idx       = M0_address[1:0];
    assign start_mul = wr_en & (M0_address == 8'h03) & M0_dout[0];
    assign start_add = wr_en & (M0_address == 8'h04) & M0_dout[0];

    matrix_bus_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo_a (
        .clk(clk), .reset_n(reset_n),
        .push_i(wr_en & (M0_address == 8'h00)), .wdata_i(m_din_q),
        .pop_i(pop), .rdata_o(fa)
    );

    matrix_bus_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo_b (
        .clk(clk), .reset_n(reset_n),
        .push_i(wr_en & (M0_address == 8'h01)), .wdata_i(m_din_q),
        .pop_i(pop), .rdata_o(fb)
    );

    always_comb begin
        rdata = '0;
        case (M0_address)
            8'h02:   rdata = {{(DATA_W-1){1'b0}}, int_en_q};
            8'h05:   rdata = {{(DATA_W-2){1'b0}}, add_done_q, mul_done_q};
            default: begin
                case (M0_address[7:2])
                    6'd8:    rdata = a_q[idx];
                    6'd16:   rdata = b_q[idx];
                    6'd24:   rdata = c_q[idx];
                    6'd32:   rdata = d_q[idx];
                    default: rdata = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        pop     = 1'b0;
        c_we    = 1'b0;
        d_we    = 1'b0;
        mul_fin = 1'b0;
        add_fin = 1'b0;
        mul_sum = f_add(acc_q, f_mul(fa, fb));
        add_sum = f_add(a_q[cnt_q[1:0]], b_q[cnt_q[1:0]]);
        case (state_q)
            S_IDLE: begin
                if (start_mul) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (start_add) begin
                    state_d = S_ADD;
                    cnt_d   = '0;
                end
            end
            S_MUL: begin
                pop   = 1'b1;
                cnt_d = cnt_q + 3'd1;
                // Every second pop closes one dot product into C[cnt/2].
                if (cnt_q[0]) begin
                    c_we  = 1'b1;
                    acc_d = '0;
                end else begin
                    acc_d = mul_sum;
                end
                if (cnt_q == 3'd7) begin
                    state_d = S_IDLE;
                    mul_fin = 1'b1;
                end
            end
            S_ADD: begin
                d_we  = 1'b1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd3) begin
                    state_d = S_IDLE;
                    add_fin = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            m0_grant_q <= 1'b0;
            m_din_q    <= '0;
            int_en_q   <= 1'b0;
            mul_done_q <= 1'b0;
            add_done_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
                d_q[i] <= '0;
            end
        end else begin
            m0_grant_q <= M0_req;
            if (rd_en)
                m_din_q <= rdata;
            if (wr_en) begin
                case (M0_address)
                    8'h02: int_en_q <= M0_dout[0];
                    8'h03: if (M0_dout[0]) mul_done_q <= 1'b0;
                    8'h04: if (M0_dout[0]) add_done_q <= 1'b0;
                    8'h05: begin
                        mul_done_q <= 1'b0;
                        add_done_q <= 1'b0;
                    end
                    default: begin
                        if (M0_address[7:2] == 6'd8)  a_q[idx] <= M0_dout;
                        if (M0_address[7:2] == 6'd16) b_q[idx] <= M0_dout;
                    end
                endcase
            end
            if (c_we)    c_q[cnt_q[2:1]] <= mul_sum;
            if (d_we)    d_q[cnt_q[1:0]] <= add_sum;
            if (mul_fin) mul_done_q <= 1'b1;
            if (add_fin) add_done_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_matrix_bus_top.sv
// tb/tb_matrix_bus_top.sv - directed table-driven bench for matrix_bus_top.
module tb_matrix_bus_top;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        M0_req, M0_wr;
    logic [7:0]  M0_address;
    logic [31:0] M0_dout;
    logic        M0_grant, M1_grant, m_interrupt, multi_opdone;
    logic [31:0] M_din;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    matrix_bus_top #(.FIFO_DEPTH(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .M0_req(M0_req), .M0_wr(M0_wr),
        .M0_address(M0_address), .M0_dout(M0_dout), .M0_grant(M0_grant),
        .M1_grant(M1_grant), .M_din(M_din), .m_interrupt(m_interrupt),
        .multi_opdone(multi_opdone)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h need %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        vecs.push_back('{wr: 1'b1, addr: a, data: d, chk: 1'b0, exp: 32'h0});
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        vecs.push_back('{wr: 1'b0, addr: a, data: 32'h0, chk: 1'b1, exp: e});
    endtask

    task automatic run();
        foreach (vecs[i]) begin
            M0_wr      = vecs[i].wr;
            M0_address = vecs[i].addr;
            M0_dout    = vecs[i].data;
            step();
            if (vecs[i].chk)
                check($sformatf("rd[%0d]@%02h", i, vecs[i].addr), M_din, vecs[i].exp);
        end
        vecs.delete();
        M0_wr      = 1'b0;
        M0_address = 8'h05;
        M0_dout    = 32'h0;
    endtask

    // Issue a start write and count the cycles the engine holds the bus.
    task automatic start_and_wait(input logic [7:0] a, input int exp_cycles, input string name);
        int n;
        logic [31:0] held;
        M0_wr = 1'b1; M0_address = a; M0_dout = 32'h1;
        step();
        M0_wr = 1'b0; M0_address = 8'h05; M0_dout = 32'h0;
        held = M_din;
        n = 0;
        while (M1_grant && n < 40) begin
            if (M0_grant) check({name, "_grant_overlap"}, 32'(M0_grant), 32'h0);
            n++;
            step();
        end
        check({name, "_busy_cycles"}, n, exp_cycles);
        check({name, "_din_hold"}, M_din, held);
    endtask

    task automatic fill_a_std();
        int ord[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        for (int i = 0; i < 8; i++) begin
            rd(8'h20 + 8'(ord[i]), 32'd10 + 32'(ord[i]));
            wr(8'h00, 32'hDEAD_BEEF);
        end
    endtask

    task automatic fill_b_std();
        int ord[8] = '{0, 2, 1, 3, 0, 2, 1, 3};
        for (int i = 0; i < 8; i++) begin
            rd(8'h40 + 8'(ord[i]), 32'd14 + 32'(ord[i]));
            wr(8'h01, 32'hDEAD_BEEF);
        end
    endtask

    task automatic read_c(input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
        rd(8'h60, e0); rd(8'h61, e1); rd(8'h62, e2); rd(8'h63, e3);
        run();
    endtask

    initial begin
        reset_n = 1'b1; M0_req = 1'b0; M0_wr = 1'b0; M0_address = 8'h0; M0_dout = 32'h0;
        step(); step();
        check("rst_m0_grant", 32'(M0_grant), 32'h0);
        check("rst_m_din", M_din, 32'h0);

        reset_n = 1'b0; M0_req = 1'b1; M0_address = 8'h05;
        step();
        check("m0_grant_after_req", 32'(M0_grant), 32'h1);
        check("m1_grant_idle", 32'(M1_grant), 32'h0);
        check("irq_idle", 32'(m_interrupt), 32'h0);
        check("mul_done_idle", 32'(multi_opdone), 32'h0);

        for (int i = 0; i < 4; i++) wr(8'h20 + 8'(i), 32'd10 + 32'(i));
        for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i), 32'd14 + 32'(i));
        for (int i = 0; i < 4; i++) rd(8'h20 + 8'(i), 32'd10 + 32'(i));
        for (int i = 0; i < 4; i++) rd(8'h40 + 8'(i), 32'd14 + 32'(i));
        rd(8'h07, 32'h0);
        fill_a_std();
        fill_b_std();
        run();

        start_and_wait(8'h03, 8, "mul1");
        check("mul1_opdone", 32'(multi_opdone), 32'h1);
        read_c(32'd316, 32'd337, 32'd376, 32'd401);

        wr(8'h02, 32'h1);
        rd(8'h02, 32'h1);
        run();
        start_and_wait(8'h04, 4, "add1");
        check("add1_irq", 32'(m_interrupt), 32'h1);
        rd(8'h80, 32'd24); rd(8'h81, 32'd26); rd(8'h82, 32'd28); rd(8'h83, 32'd30);
        rd(8'h05, 32'h3);
        wr(8'h05, 32'h0);
        rd(8'h05, 32'h0);
        run();
        check("irq_cleared", 32'(m_interrupt), 32'h0);
        check("opdone_cleared", 32'(multi_opdone), 32'h0);

        // Ninth push into a full FIFO_A must not disturb the first eight entries.
        fill_a_std();
        rd(8'h40, 32'd14);
        wr(8'h00, 32'h0);
        fill_b_std();
        run();
        start_and_wait(8'h03, 8, "mul2");
        read_c(32'd316, 32'd337, 32'd376, 32'd401);

        rd(8'h20, 32'd10); wr(8'h00, 32'h0); wr(8'h00, 32'h0);
        run();
        start_and_wait(8'h03, 8, "mul_empty_b");
        read_c(32'd0, 32'd0, 32'd0, 32'd0);

        rd(8'h21, 32'd11);
        run();
        M0_wr = 1'b1; M0_address = 8'h03; M0_dout = 32'h1;
        step();
        M0_wr = 1'b0; M0_address = 8'h05;
        check("mul3_busy", 32'(M1_grant), 32'h1);
        step(); step();
        reset_n = 1'b1;
        step();
        check("midrst_m1_grant", 32'(M1_grant), 32'h0);
        check("midrst_m0_grant", 32'(M0_grant), 32'h0);
        check("midrst_m_din", M_din, 32'h0);
        check("midrst_outs", {30'h0, m_interrupt, multi_opdone}, 32'h0);
        reset_n = 1'b0;
        step();
        rd(8'h20, 32'h0);
        rd(8'h60, 32'h0);
        rd(8'h02, 32'h0);
        wr(8'h20, 32'hFFFF_FFFF);
        wr(8'h40, 32'hFFFF_FFFF);
        run();
        start_and_wait(8'h04, 4, "add_sat");
        check("add_irq_disabled", 32'(m_interrupt), 32'h0);
`ifdef MATRIX_SAT_EN
        rd(8'h80, 32'hFFFF_FFFF);
`else
        rd(8'h80, 32'hFFFF_FFFE);
`endif
        rd(8'h81, 32'h0);
        run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
